cmd_bus_initiator: RTL
======================

// Module: cmd_bus_initiator
// PURPOSE
//  Initiator end of the register command bus (enable_cmd/write_read/addr_frame/write_data_frame -> busy/read_data_frame)
//  used by clock/reset control and other register slaves. Takes one request at a time from the upstream frame
//  decoder (valid/ready), issues a single bus command, tracks slave busy with a timeout, and returns a response
//  (read data or write ack, plus error flag). Sits in the Main_CLOCK domain next to the slaves it drives.
// PARAMETERS
//  TIMEOUT_CYCLES  1024  max cycles busy may stay high before the command is abandoned as error (>=4)
//  RISE_WINDOW     2     cycles after enable_cmd within which busy must rise; otherwise zero-wait completion (1..4)
// PORTS
//  Clock            in   1   single clock (Main_CLOCK domain)
//  Reset_N          in   1   asynchronous, active-low reset
//  Req_Valid        in   1   upstream request valid
//  Req_Ready        out  1   initiator idle, request accepted when Req_Valid&Req_Ready
//  Req_Write        in   1   1=write, 0=read
//  Req_Addr         in   8   register address
//  Req_Data         in   16  write data (ignored for reads)
//  Rsp_Valid        out  1   response valid, held until Rsp_Ready
//  Rsp_Ready        in   1   downstream accepts response
//  Rsp_Write        out  1   echo of Req_Write for this response
//  Rsp_Data         out  16  captured read_data_frame (reads); 16'h0000 for writes and on error
//  Rsp_Error        out  1   1 = busy timeout
//  enable_cmd       out  1   one-cycle command strobe to slave
//  write_read       out  1   1=write, 0=read; stable from strobe until response
//  addr_frame       out  8   address; stable from strobe until response
//  write_data_frame out  16  write data; stable from strobe until response
//  busy             in   1   slave busy
//  read_data_frame  in   16  slave read data, valid when busy falls (or at end of rise window)
//  Timeout_Count    out  8   saturating count of timed-out commands (status)
// BEHAVIOUR
//  - Reset: state IDLE; Req_Ready=1 only after reset release (0 during reset); all other outputs 0, Timeout_Count=0.
//  - States: IDLE -> ISSUE -> WAIT_RISE -> WAIT_FALL -> RESPOND -> IDLE.
//  - IDLE: Req_Ready=1. On Req_Valid: register write/addr/data onto bus outputs, go ISSUE. Req_Ready=0 in all other states.
//  - ISSUE: enable_cmd=1 for exactly this cycle (strobe occurs 1 cycle after handshake). Next WAIT_RISE, counter=0.
//  - WAIT_RISE: busy=1 -> WAIT_FALL (timeout counter cleared). No busy within RISE_WINDOW cycles -> capture
//    read_data_frame, go RESPOND, Rsp_Error=0 (zero-wait slave).
//  - WAIT_FALL: busy=0 -> capture read_data_frame that cycle, RESPOND. Counter reaches TIMEOUT_CYCLES with busy
//    still 1 -> RESPOND with Rsp_Error=1, Rsp_Data=0, Timeout_Count+=1 (saturates at 255).
//  - RESPOND: Rsp_Valid=1, outputs stable; on Rsp_Ready go IDLE same edge. Back-to-back: next request may be
//    accepted in IDLE the cycle after; minimum 5 cycles handshake-to-handshake with zero-wait slave and Rsp_Ready=1.
//  - Writes: Rsp_Data forced 16'h0000 regardless of read_data_frame.
//  - busy already high in ISSUE cycle is ignored; only WAIT_RISE samples rise. busy glitch after WAIT_FALL is ignored.
//  - Timeout counter width = clog2(TIMEOUT_CYCLES+1); no wrap (compare by equality).
//  - Reset mid-command: all outputs return to reset values asynchronously; no response emitted for aborted command.
// STRUCTURE
//  - Shared package: state enum encoding, write_read polarity constants (CMD_WRITE=1, CMD_READ=0), bus widths
//    (ADDR_W=8, DATA_W=16), rsp error code.
//  - Single module; no sub-modules. One FSM process, one datapath register process, one counter process.
// TESTING
//  - Write zero-wait: Req W addr 8'h02 data 16'h0003, busy never rises -> enable_cmd 1 cycle, Rsp_Valid after
//    RISE_WINDOW, Rsp_Error=0, Rsp_Data=0.
//  - Read with wait: Req R addr 8'h10, busy high cycles 1..6, read_data_frame=16'h00A5 at fall -> Rsp_Data=16'h00A5.
//  - Timeout: busy stuck 1 -> Rsp_Error=1 exactly TIMEOUT_CYCLES after busy rise, Timeout_Count=1; 256 repeats -> 255.
//  - Backpressure: Rsp_Ready low 10 cycles -> Rsp_* and bus outputs stable, Req_Ready=0, no second enable_cmd.
//  - Reset mid WAIT_FALL: Reset_N low -> enable_cmd/Rsp_Valid 0, state IDLE; new request after release completes normally.
//  - Back-to-back: two requests queued, Rsp_Ready=1 -> exactly two enable_cmd strobes, responses in order.

Source files
------------

// File: rtl/cmd_bus_initiator_pkg.sv
// Shared definitions for the register command bus initiator: bus widths,
// command polarity, response error codes and the initiator FSM encoding.
package cmd_bus_initiator_pkg;

    localparam int unsigned ADDR_W = 8;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned STAT_W = 8;

    localparam logic CMD_WRITE = 1'b1;
    localparam logic CMD_READ  = 1'b0;

    localparam logic RSP_OK      = 1'b0;
    localparam logic RSP_TIMEOUT = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_RISE,
        ST_WAIT_FALL,
        ST_RESPOND
    } state_t;

endpackage

// File: rtl/cmd_bus_initiator.sv
// Initiator end of the register command bus: accepts one request, strobes the
// slave, follows its busy handshake with a timeout and returns one response.
module cmd_bus_initiator
    import cmd_bus_initiator_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter int unsigned RISE_WINDOW    = 2
) (
    input  logic              Clock,
    input  logic              Reset_N,
    input  logic              Req_Valid,
    output logic              Req_Ready,
    input  logic              Req_Write,
    input  logic [ADDR_W-1:0] Req_Addr,
    input  logic [DATA_W-1:0] Req_Data,
    output logic              Rsp_Valid,
    input  logic              Rsp_Ready,
    output logic              Rsp_Write,
    output logic [DATA_W-1:0] Rsp_Data,
    output logic              Rsp_Error,
    output logic              enable_cmd,
    output logic              write_read,
    output logic [ADDR_W-1:0] addr_frame,
    output logic [DATA_W-1:0] write_data_frame,
    input  logic              busy,
    input  logic [DATA_W-1:0] read_data_frame,
    output logic [STAT_W-1:0] Timeout_Count
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] RISE_LAST    = CNT_W'(RISE_WINDOW - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic             cnt_clear;
    logic             load_req;
    logic             capture_ok;
    logic             capture_err;
    logic             ready_en;

    // FSM state register
    always_ff @(posedge Clock or negedge Reset_N) begin
        if (!Reset_N) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and control decode; a falling busy wins over a timeout in the same cycle
    always_comb begin
        state_next  = state;
        cnt_clear   = 1'b0;
        load_req    = 1'b0;
        capture_ok  = 1'b0;
        capture_err = 1'b0;
        case (state)
            ST_IDLE: begin
                if (Req_Valid && ready_en) begin
                    load_req   = 1'b1;
                    state_next = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                cnt_clear  = 1'b1;
                state_next = ST_WAIT_RISE;
            end
            ST_WAIT_RISE: begin
                if (busy) begin
                    cnt_clear  = 1'b1;
                    state_next = ST_WAIT_FALL;
                end else if (cnt == RISE_LAST) begin
                    capture_ok = 1'b1;
                    state_next = ST_RESPOND;
                end
            end
            ST_WAIT_FALL: begin
                if (!busy) begin
                    capture_ok = 1'b1;
                    state_next = ST_RESPOND;
                end else if (cnt == TIMEOUT_LAST) begin
                    capture_err = 1'b1;
                    state_next  = ST_RESPOND;
                end
            end
            ST_RESPOND: begin
                if (Rsp_Ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Wait counter shared by the rise window and the busy timeout
    always_ff @(posedge Clock or negedge Reset_N) begin
        if (!Reset_N) begin
            cnt <= '0;
        end else if (cnt_clear) begin
            cnt <= '0;
        end else if (state == ST_WAIT_RISE || state == ST_WAIT_FALL) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // Datapath: bus frame, response capture and timeout statistics
    always_ff @(posedge Clock or negedge Reset_N) begin
        if (!Reset_N) begin
            ready_en         <= 1'b0;
            write_read       <= 1'b0;
            addr_frame       <= '0;
            write_data_frame <= '0;
            Rsp_Write        <= 1'b0;
            Rsp_Data         <= '0;
            Rsp_Error        <= RSP_OK;
            Timeout_Count    <= '0;
        end else begin
            ready_en <= 1'b1;
            if (load_req) begin
                write_read       <= Req_Write;
                addr_frame       <= Req_Addr;
                write_data_frame <= Req_Data;
            end
            if (capture_ok) begin
                Rsp_Write <= write_read;
                Rsp_Data  <= (write_read == CMD_READ) ? read_data_frame : '0;
                Rsp_Error <= RSP_OK;
            end
            if (capture_err) begin
                Rsp_Write <= write_read;
                Rsp_Data  <= '0;
                Rsp_Error <= RSP_TIMEOUT;
                if (Timeout_Count != '1) begin
                    Timeout_Count <= Timeout_Count + STAT_W'(1);
                end
            end
        end
    end

    assign Req_Ready  = (state == ST_IDLE) && ready_en;
    assign enable_cmd = (state == ST_ISSUE);
    assign Rsp_Valid  = (state == ST_RESPOND);

endmodule
